// File: rtl/thresh_preset_commit.sv
// rtl/thresh_preset_commit.sv - commits a settled threshold preset to the ACL2 driver via req/ack
module thresh_preset_commit #(
    parameter int unsigned parm_settle_cycles = 10_000_000,
    parameter int unsigned parm_ack_timeout   = 2_000_000,
    parameter int unsigned parm_cnt_width     = 24
) (
    input  logic        i_clk_20mhz,
    input  logic        i_rst_20mhz,
    input  logic [3:0]  i_value_enum,
    input  logic [15:0] i_value_thresh,
    input  logic [15:0] i_value_timer,
    input  logic        i_acl_ready,
    input  logic        i_cfg_ack,
    output logic        o_cfg_req,
    output logic [15:0] o_cfg_thresh,
    output logic [15:0] o_cfg_timer,
    output logic [3:0]  o_cfg_enum,
    output logic        o_pending,
    output logic        o_commit_pulse,
    output logic        o_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT_READY,
        ST_REQ
    } state_t;

    localparam logic [parm_cnt_width-1:0] SETTLE_LAST = parm_cnt_width'(parm_settle_cycles - 1);
    localparam logic [parm_cnt_width-1:0] ACK_LAST    = parm_cnt_width'(parm_ack_timeout - 1);
    localparam logic [parm_cnt_width-1:0] CNT_MAX     = '1;

    state_t                    state_q, state_d;
    logic [parm_cnt_width-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]                seen_enum_q;
    logic [3:0]                pend_enum_q, pend_enum_d;
    logic [3:0]                cfg_enum_q, cfg_enum_d;
    logic [15:0]               cfg_thresh_q, cfg_thresh_d;
    logic [15:0]               cfg_timer_q, cfg_timer_d;
    logic                      cfg_req_q, cfg_req_d;
    logic                      valid_q, valid_d;
    logic                      pulse_q, pulse_d;
    logic                      err_q, err_d;
    logic                      change;

    assign change  = (i_value_enum != seen_enum_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_inc;
        pend_enum_d  = pend_enum_q;
        cfg_enum_d   = cfg_enum_q;
        cfg_thresh_d = cfg_thresh_q;
        cfg_timer_d  = cfg_timer_q;
        cfg_req_d    = cfg_req_q;
        valid_d      = valid_q;
        pulse_d      = 1'b0;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (change) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (change) begin
                    cnt_d = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    // Selection returned to what the driver already holds: nothing to send.
                    if (valid_q && (i_value_enum == cfg_enum_q)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_READY;
                    end
                end
            end
            ST_WAIT_READY: begin
                cnt_d = '0;
                if (change) begin
                    state_d = ST_SETTLE;
                end else if (i_acl_ready) begin
                    cfg_thresh_d = i_value_thresh;
                    cfg_timer_d  = i_value_timer;
                    pend_enum_d  = i_value_enum;
                    cfg_req_d    = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_cfg_ack) begin
                    cfg_req_d  = 1'b0;
                    cfg_enum_d = pend_enum_q;
                    valid_d    = 1'b1;
                    pulse_d    = 1'b1;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    state_d    = (i_value_enum != pend_enum_q) ? ST_SETTLE : ST_IDLE;
                end else if (cnt_q == ACK_LAST) begin
                    cfg_req_d = 1'b0;
                    err_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_READY;
                end
            end
            default: begin
                state_d = ST_WAIT_READY;
                cnt_d   = '0;
            end
        endcase
    end

    // Sampled through reset so the preset present at release counts as settled.
    always_ff @(posedge i_clk_20mhz) begin
        seen_enum_q <= i_value_enum;
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (i_rst_20mhz) begin
            state_q      <= ST_WAIT_READY;
            cnt_q        <= '0;
            pend_enum_q  <= '0;
            cfg_enum_q   <= '0;
            cfg_thresh_q <= '0;
            cfg_timer_q  <= '0;
            cfg_req_q    <= 1'b0;
            valid_q      <= 1'b0;
            pulse_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_enum_q  <= pend_enum_d;
            cfg_enum_q   <= cfg_enum_d;
            cfg_thresh_q <= cfg_thresh_d;
            cfg_timer_q  <= cfg_timer_d;
            cfg_req_q    <= cfg_req_d;
            valid_q      <= valid_d;
            pulse_q      <= pulse_d;
            err_q        <= err_d;
        end
    end

    assign o_cfg_req      = cfg_req_q;
    assign o_cfg_thresh   = cfg_thresh_q;
    assign o_cfg_timer    = cfg_timer_q;
    assign o_cfg_enum     = cfg_enum_q;
    assign o_pending      = (state_q != ST_IDLE);
    assign o_commit_pulse = pulse_q;
    assign o_timeout_err  = err_q;

endmodule

// File: tb/tb_thresh_preset_commit.sv
// tb/tb_thresh_preset_commit.sv - directed self-checking bench for thresh_preset_commit
module tb_thresh_preset_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  value_enum;
    logic [15:0] value_thresh;
    logic [15:0] value_timer;
    logic        acl_ready;
    logic        cfg_ack;
    logic        cfg_req;
    logic [15:0] cfg_thresh;
    logic [15:0] cfg_timer;
    logic [3:0]  cfg_enum;
    logic        pending;
    logic        commit_pulse;
    logic        timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pulse_cnt = 0;

    thresh_preset_commit #(
        .parm_settle_cycles(8),
        .parm_ack_timeout  (16),
        .parm_cnt_width    (8)
    ) dut (
        .i_clk_20mhz   (clk),
        .i_rst_20mhz   (rst),
        .i_value_enum  (value_enum),
        .i_value_thresh(value_thresh),
        .i_value_timer (value_timer),
        .i_acl_ready   (acl_ready),
        .i_cfg_ack     (cfg_ack),
        .o_cfg_req     (cfg_req),
        .o_cfg_thresh  (cfg_thresh),
        .o_cfg_timer   (cfg_timer),
        .o_cfg_enum    (cfg_enum),
        .o_pending     (pending),
        .o_commit_pulse(commit_pulse),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (commit_pulse === 1'b1) pulse_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_preset(input logic [3:0] e, input logic [15:0] th, input logic [15:0] tm);
        value_enum   = e;
        value_thresh = th;
        value_timer  = tm;
    endtask

    // Returns number of edges until o_cfg_req is seen high, or -1 on expiry.
    task automatic wait_req(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (cfg_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        cfg_ack = 1'b1;
        tick();
        cfg_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_preset(4'd0, 16'h0100, 16'h0020);
        acl_ready = 1'b1;
        cfg_ack   = 1'b0;
        tick();
        tick();
        total_cnt++; if (cfg_req !== 1'b0) $display("FAIL rst_req got %0h want 0", cfg_req); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0) $display("FAIL rst_thresh got %0h want 0", cfg_thresh); else pass_cnt++;
        total_cnt++; if (cfg_timer !== 16'h0) $display("FAIL rst_timer got %0h want 0", cfg_timer); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h0) $display("FAIL rst_enum got %0h want 0", cfg_enum); else pass_cnt++;
        total_cnt++; if (commit_pulse !== 1'b0) $display("FAIL rst_pulse got %0h want 0", commit_pulse); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL rst_err got %0h want 0", timeout_err); else pass_cnt++;
        total_cnt++; if (pending !== 1'b1) $display("FAIL rst_pending got %0h want 1", pending); else pass_cnt++;
        rst = 1'b0;
        total_cnt++; if (cfg_req !== 1'b0) $display("FAIL init_capture_req got %0h want 0", cfg_req); else pass_cnt++;
        tick();
        total_cnt++; if (cfg_req !== 1'b1) $display("FAIL init_req got %0h want 1", cfg_req); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0100) $display("FAIL init_thresh got %0h want 0100", cfg_thresh); else pass_cnt++;
        total_cnt++; if (cfg_timer !== 16'h0020) $display("FAIL init_timer got %0h want 0020", cfg_timer); else pass_cnt++;
        tick();
        tick();
        pulse_ack();
        total_cnt++; if (cfg_req !== 1'b0) $display("FAIL init_ack_req got %0h want 0", cfg_req); else pass_cnt++;
        total_cnt++; if (commit_pulse !== 1'b1) $display("FAIL init_pulse got %0h want 1", commit_pulse); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h0) $display("FAIL init_enum got %0h want 0", cfg_enum); else pass_cnt++;
        total_cnt++; if (pending !== 1'b0) $display("FAIL init_pending got %0h want 0", pending); else pass_cnt++;
        tick();
        total_cnt++; if (commit_pulse !== 1'b0) $display("FAIL init_pulse_end got %0h want 0", commit_pulse); else pass_cnt++;
    endtask

    task automatic test_cycle_back();
        int req_seen = 0;
        set_preset(4'd1, 16'h0111, 16'h0011);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cfg_req === 1'b1) req_seen++;
        end
        set_preset(4'd0, 16'h0100, 16'h0020);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cfg_req === 1'b1) req_seen++;
        end
        total_cnt++; if (req_seen !== 0) $display("FAIL cycle_back_req got %0d want 0", req_seen); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h0) $display("FAIL cycle_back_enum got %0h want 0", cfg_enum); else pass_cnt++;
        total_cnt++; if (pending !== 1'b0) $display("FAIL cycle_back_pending got %0h want 0", pending); else pass_cnt++;
    endtask

    task automatic test_settle();
        int n;
        set_preset(4'd1, 16'h0111, 16'h0011);
        for (int i = 0; i < 5; i++) tick();
        set_preset(4'd2, 16'h0222, 16'h0022);
        wait_req(40, n);
        total_cnt++; if (n !== 10) $display("FAIL settle_latency got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0222) $display("FAIL settle_thresh got %0h want 0222", cfg_thresh); else pass_cnt++;
        total_cnt++; if (cfg_timer !== 16'h0022) $display("FAIL settle_timer got %0h want 0022", cfg_timer); else pass_cnt++;
        value_thresh = 16'h0999;
        tick();
        total_cnt++; if (cfg_thresh !== 16'h0222) $display("FAIL settle_frozen got %0h want 0222", cfg_thresh); else pass_cnt++;
        value_thresh = 16'h0222;
        pulse_ack();
        total_cnt++; if (cfg_enum !== 4'h2) $display("FAIL settle_enum got %0h want 2", cfg_enum); else pass_cnt++;
        total_cnt++; if (commit_pulse !== 1'b1) $display("FAIL settle_pulse got %0h want 1", commit_pulse); else pass_cnt++;
        tick();
    endtask

    task automatic test_not_ready();
        int n;
        int req_seen = 0;
        acl_ready = 1'b0;
        set_preset(4'd6, 16'h0666, 16'h0066);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cfg_req === 1'b1) req_seen++;
        end
        total_cnt++; if (pending !== 1'b1) $display("FAIL nready_pending got %0h want 1", pending); else pass_cnt++;
        set_preset(4'd7, 16'h0777, 16'h0077);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cfg_req === 1'b1) req_seen++;
        end
        total_cnt++; if (req_seen !== 0) $display("FAIL nready_req got %0d want 0", req_seen); else pass_cnt++;
        acl_ready = 1'b1;
        wait_req(20, n);
        total_cnt++; if (n !== 2) $display("FAIL nready_latency got %0d want 2", n); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0777) $display("FAIL nready_thresh got %0h want 0777", cfg_thresh); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (cfg_enum !== 4'h7) $display("FAIL nready_enum got %0h want 7", cfg_enum); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int high;
        int p0;
        set_preset(4'd5, 16'h0555, 16'h0055);
        wait_req(40, n);
        total_cnt++; if (n !== 10) $display("FAIL to_latency got %0d want 10", n); else pass_cnt++;
        high = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cfg_req === 1'b0) begin
                high = i;
                break;
            end
        end
        total_cnt++; if (high !== 16) $display("FAIL to_req_len got %0d want 16", high); else pass_cnt++;
        total_cnt++; if (timeout_err !== 1'b1) $display("FAIL to_err got %0h want 1", timeout_err); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h7) $display("FAIL to_enum_kept got %0h want 7", cfg_enum); else pass_cnt++;
        wait_req(20, n);
        total_cnt++; if (n !== 1) $display("FAIL to_retry got %0d want 1", n); else pass_cnt++;
        p0 = pulse_cnt;
        pulse_ack();
        total_cnt++; if (timeout_err !== 1'b0) $display("FAIL to_err_clr got %0h want 0", timeout_err); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h5) $display("FAIL to_enum got %0h want 5", cfg_enum); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL to_pulses got %0d want 1", pulse_cnt - p0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        int p0;
        set_preset(4'd3, 16'h0333, 16'h0033);
        wait_req(40, n);
        total_cnt++; if (n !== 10) $display("FAIL b2b_latency got %0d want 10", n); else pass_cnt++;
        set_preset(4'd4, 16'h0444, 16'h0044);
        tick();
        tick();
        total_cnt++; if (cfg_req !== 1'b1) $display("FAIL b2b_req_held got %0h want 1", cfg_req); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0333) $display("FAIL b2b_frozen got %0h want 0333", cfg_thresh); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (cfg_enum !== 4'h3) $display("FAIL b2b_enum1 got %0h want 3", cfg_enum); else pass_cnt++;
        total_cnt++; if (commit_pulse !== 1'b1) $display("FAIL b2b_pulse1 got %0h want 1", commit_pulse); else pass_cnt++;
        total_cnt++; if (pending !== 1'b1) $display("FAIL b2b_pending got %0h want 1", pending); else pass_cnt++;
        wait_req(40, n);
        total_cnt++; if (n !== 9) $display("FAIL b2b_latency2 got %0d want 9", n); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0444) $display("FAIL b2b_thresh2 got %0h want 0444", cfg_thresh); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (cfg_enum !== 4'h4) $display("FAIL b2b_enum2 got %0h want 4", cfg_enum); else pass_cnt++;
        tick();
        p0 = pulse_cnt;
        pulse_ack();
        tick();
        total_cnt++; if (pulse_cnt - p0 !== 0) $display("FAIL stray_ack_pulse got %0d want 0", pulse_cnt - p0); else pass_cnt++;
        total_cnt++; if (cfg_req !== 1'b0) $display("FAIL stray_ack_req got %0h want 0", cfg_req); else pass_cnt++;
        total_cnt++; if (pending !== 1'b0) $display("FAIL stray_ack_pending got %0h want 0", pending); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h4) $display("FAIL stray_ack_enum got %0h want 4", cfg_enum); else pass_cnt++;
    endtask

    task automatic test_reset_mid_req();
        int n;
        set_preset(4'd5, 16'h0555, 16'h0055);
        wait_req(40, n);
        total_cnt++; if (n !== 10) $display("FAIL mid_latency got %0d want 10", n); else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++; if (cfg_req !== 1'b0) $display("FAIL mid_rst_req got %0h want 0", cfg_req); else pass_cnt++;
        total_cnt++; if (cfg_enum !== 4'h0) $display("FAIL mid_rst_enum got %0h want 0", cfg_enum); else pass_cnt++;
        rst = 1'b0;
        wait_req(5, n);
        total_cnt++; if (n !== 1) $display("FAIL mid_recommit got %0d want 1", n); else pass_cnt++;
        total_cnt++; if (cfg_thresh !== 16'h0555) $display("FAIL mid_thresh got %0h want 0555", cfg_thresh); else pass_cnt++;
        pulse_ack();
        total_cnt++; if (cfg_enum !== 4'h5) $display("FAIL mid_enum got %0h want 5", cfg_enum); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cycle_back();
        test_settle();
        test_not_ready();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
